// File: rtl/uart_rx_fifo_if.sv
// Receive-data handshake between the UART receiver and its consumer.
// The master drives the head byte and its valid flag. The slave answers with ready.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive front end.
// It synchronises the serial pin, deframes 8N1 characters (LSB first) and
// buffers the bytes in a small FIFO that is read through a valid/ready handshake.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing. An even-parity
// bit is then checked between bit 7 and the stop bit.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        uart_rx,
  uart_rx_fifo_if.master              rx_bus,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        err_clr
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [7:0]      head_q, head_d;
  logic            ferr_q, ferr_d, ovr_q, ovr_d;
  logic            pop, full, push_ok, ovr_set;

  logic bit_tick, half_tick;
  assign bit_tick  = (cnt_q == CW'(CPB - 1));
  assign half_tick = (cnt_q == CW'(CPB / 2 - 1));

  // Two-flop synchronizer on the asynchronous pin; idles high.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Deframing FSM: next state, bit sampling and push/error strobes.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: if (!rx_s_q) state_d = S_START;
      S_START: begin
        if (half_tick) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          if ((^shift_q) ^ rx_s_q) begin
            ferr_set  = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The bit timer restarts on every state change, so each state measures from its own entry.
    if ((state_d != state_q) || bit_tick) cnt_d = '0;
    else                                  cnt_d = cnt_q + CW'(1);
  end

  // FSM and bit-timer registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // FIFO control. The head register is preloaded from the next entry, so a pop never leaves a bubble.
  always_comb begin
    pop      = (count_q != '0) && rx_bus.rx_ready;
    full     = (count_q == CNTW'(FIFO_DEPTH));
    push_ok  = push && (!full || pop);
    ovr_set  = push && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CNTW'(1);
    else if (!push_ok && pop) count_d = count_q - CNTW'(1);
    head_d = head_q;
    if (count_q == '0 || (pop && count_q == CNTW'(1))) begin
      if (push_ok) head_d = shift_q;
    end else if (pop) begin
      head_d = mem[rd_ptr_q + AW'(1)];
    end
    ferr_d = ferr_set ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
    ovr_d  = ovr_set  ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
  end

  // Storage array: written on an accepted push; it is never reset.
  always_ff @(posedge sysclk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers, occupancy, head byte and sticky error flags.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_bus.rx_data  = head_q;
  assign rx_bus.rx_valid = (count_q != '0);
  assign rx_count        = count_q;
  assign frame_err       = ferr_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. It uses a short bit period (16 sysclk per bit).
// A queue-based model tracks the FIFO contents and the sticky error flags.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       sysclk = 1'b0;
  logic       reset, uart_rx, err_clr;
  logic [2:0] rx_count;
  logic       frame_err, overrun;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_bus    (bus),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #10 sysclk = ~sysclk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, " count"}, 32'(rx_count), 32'(model_q.size()));
    check_val({tag, " valid"}, 32'(bus.rx_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) check_val({tag, " data"}, 32'(bus.rx_data), 32'(model_q[0]));
    check_val({tag, " frame_err"}, 32'(frame_err), 32'(m_ferr));
    check_val({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
  endtask

  // Sends one frame, starting at a negedge. If pop_at_stop is set, rx_ready is
  // raised for exactly the cycle whose rising edge samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit pop_at_stop);
    logic [NB-1:0] bits;
    bit popped;
    bits      = '0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9] = ^b;
`endif
    bits[NB-1] = stop_v;
    popped = 1'b0;
    for (int i = 0; i < NB; i++) begin
      uart_rx = bits[i];
      if (i == NB - 1 && pop_at_stop) begin
        repeat (2 + CPB / 2) @(negedge sysclk);
        check_val("stop-pop valid", 32'(bus.rx_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) check_val("stop-pop data", 32'(bus.rx_data), 32'(model_q[0]));
        bus.rx_ready = 1'b1;
        @(negedge sysclk);
        bus.rx_ready = 1'b0;
        repeat (CPB - 3 - CPB / 2) @(negedge sysclk);
        popped = (model_q.size() > 0);
      end else begin
        repeat (CPB) @(negedge sysclk);
      end
    end
    if (popped) void'(model_q.pop_front());
    if (stop_v) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
    $display("frame %02h stop=%0d pop_at_stop=%0d -> model count %0d", b, stop_v, pop_at_stop, model_q.size());
  endtask

  task automatic pop_one(input string tag);
    bit exp_v;
    exp_v = (model_q.size() > 0);
    check_val({tag, " pop valid"}, 32'(bus.rx_valid), 32'(exp_v));
    if (exp_v) check_val({tag, " pop data"}, 32'(bus.rx_data), 32'(model_q[0]));
    bus.rx_ready = 1'b1;
    @(negedge sysclk);
    bus.rx_ready = 1'b0;
    if (exp_v) $display("pop %02h", model_q.pop_front());
    else $display("pop on empty fifo");
    @(negedge sysclk);
    check_state({tag, " after pop"});
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge sysclk);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    $display("err_clr pulse");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; uart_rx = 1'b1; err_clr = 1'b0; bus.rx_ready = 1'b0;
    repeat (3) @(negedge sysclk);
    check_state("reset");
    check_val("reset data", 32'(bus.rx_data), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge sysclk);

    // Two frames back to back, then drain them.
    send_frame(8'h55, 1'b1, 1'b0);
    check_state("0x55");
    send_frame(8'h2A, 1'b1, 1'b0);
    check_state("0x2A");
    pop_one("first");
    pop_one("second");
    pop_one("empty");

    // Bad stop bit, then the line is held low: one error and no spurious frames.
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);
    check_state("break");
    clear_errs();
    check_state("break cleared");

    // A glitch shorter than half a bit is ignored.
    uart_rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);
    check_state("glitch");

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_state("overrun");
    for (int i = 0; i < 4; i++) pop_one("overrun drain");
    clear_errs();

    // The same, but a pop coincides with the fifth stop sample: no overrun.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, i == 5);
    check_state("full push+pop");
    for (int i = 0; i < 4; i++) pop_one("push+pop drain");

    // Reset in the middle of the data bits.
    send_frame(8'h3C, 1'b1, 1'b0);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    reset = 1'b1;
    uart_rx = 1'b1;
    model_q.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(negedge sysclk);
    check_state("mid-frame reset");
    check_val("mid-frame reset data", 32'(bus.rx_data), 32'h0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge sysclk);
    send_frame(8'hC3, 1'b1, 1'b0);
    check_state("after reset");

    // Randomised traffic against the model.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop_v;
      bit         pas;
      b      = 8'($urandom);
      stop_v = ($urandom_range(0, 7) != 0);
      pas    = ($urandom_range(0, 3) == 0);
      send_frame(b, stop_v, pas);
      if (!stop_v) begin
        repeat (CPB * $urandom_range(1, 3)) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge sysclk);
      end else begin
        repeat ($urandom_range(0, CPB / 2)) @(negedge sysclk);
      end
      check_state("random frame");
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_one("random");
      if ($urandom_range(0, 3) == 0) begin
        clear_errs();
        check_state("random clear");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
